// File: rtl/vedic_multiplier_pipe_if.sv
// Handshake bundle for vedic_multiplier_pipe: operand/tag input side and product/tag output side.
// Ports: in_valid/in_ready/A/B/in_tag (+ in_signed with VEDIC_SIGNED_EN), out_valid/out_ready/P/out_tag.
// master = producer/consumer environment view, slave = multiplier view.
interface vedic_multiplier_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [TAG_W-1:0]   in_tag;
`ifdef VEDIC_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] P;
  logic [TAG_W-1:0]   out_tag;

`ifdef VEDIC_SIGNED_EN
  modport master (output in_valid, A, B, in_tag, in_signed, out_ready,
                  input  in_ready, out_valid, P, out_tag);
  modport slave  (input  in_valid, A, B, in_tag, in_signed, out_ready,
                  output in_ready, out_valid, P, out_tag);
`else
  modport master (output in_valid, A, B, in_tag, out_ready,
                  input  in_ready, out_valid, P, out_tag);
  modport slave  (input  in_valid, A, B, in_tag, out_ready,
                  output in_ready, out_valid, P, out_tag);
`endif
endinterface

// File: rtl/vedic_multiplier_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH, one register stage per recursion level.
// Latency log2(WIDTH) cycles, one product per clock; a held output freezes the whole pipe and drops in_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport). Optional macro VEDIC_SIGNED_EN adds in_signed.
module vedic_multiplier_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vedic_multiplier_pipe_if.slave bus
);

  localparam int LAT = $clog2(WIDTH);

  // Bit offset of level k inside the flat tap bus; level m occupies (WIDTH*WIDTH) >> m bits.
  function automatic int lvl_off(input int k);
    int s;
    s = 0;
    for (int m = 0; m < k; m++) s += (WIDTH * WIDTH) >> m;
    return s;
  endfunction

  localparam int TOT     = lvl_off(LAT);
  localparam int OUT_OFF = lvl_off(LAT - 1);

  logic                 stall;
  logic                 adv;
  logic                 in_fire;
  logic [LAT-1:0]       vld_q;
  logic [TAG_W-1:0]     tag_q [LAT];
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  wire  [TOT-1:0]       taps;

  // The whole pipe moves as one shift register; only a held output stops it.
  assign stall   = bus.out_valid & ~bus.out_ready;
  assign adv     = ~stall;
  assign in_fire = bus.in_valid & adv;

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_tag   = tag_q[LAT-1];
  assign bus.P         = taps[OUT_OFF +: 2*WIDTH];

`ifdef VEDIC_SIGNED_EN
  logic           sgn_in;
  logic [LAT-1:0] sgn_q;

  // Signed pairs are multiplied as magnitudes; -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude.
  always_comb begin
    mag_a = bus.A;
    mag_b = bus.B;
    if (bus.in_signed && bus.A[WIDTH-1]) mag_a = -bus.A;
    if (bus.in_signed && bus.B[WIDTH-1]) mag_b = -bus.B;
  end

  assign sgn_in = bus.in_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= '0;
    end else if (adv) begin
      if (bus.in_valid) sgn_q[0] <= sgn_in;
      for (int k = 1; k < LAT; k++) begin
        if (vld_q[k-1]) sgn_q[k] <= sgn_q[k-1];
      end
    end
  end
`else
  assign mag_a = bus.A;
  assign mag_b = bus.B;
`endif

  // Valid bits always shift on advance so bubbles travel with data; tags only load alongside valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[LAT-2:0], bus.in_valid};
      if (bus.in_valid) tag_q[0] <= bus.in_tag;
      for (int k = 1; k < LAT; k++) begin
        if (vld_q[k-1]) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Level k holds (WIDTH/BW)^2 partial products of BW-bit digit pairs, BW = 2^(k+1).
  // Product for A-digit i and B-digit j sits at index i*NB + j.
  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int BW  = 2 ** (k + 1);
    localparam int NB  = WIDTH / BW;
    localparam int PW  = 2 * BW;
    localparam int LEN = NB * NB * PW;
    localparam int OFF = lvl_off(k);

    logic [LEN-1:0] nxt;
    logic [LEN-1:0] q;
    logic           load;

    if (k == 0) begin : g_leaf
      assign load = in_fire;

      always_comb begin
        nxt = '0;
        for (int i = 0; i < NB; i++) begin
          for (int j = 0; j < NB; j++) begin
            nxt[(i*NB + j)*PW +: PW] = {2'b00, mag_a[2*i +: 2]} * {2'b00, mag_b[2*j +: 2]};
          end
        end
      end
    end else begin : g_node
      localparam int H    = BW / 2;
      localparam int QW   = BW;
      localparam int PNB  = 2 * NB;
      localparam int POFF = lvl_off(k - 1);

      assign load = adv & vld_q[k-1];

      always_comb begin
        logic [QW-1:0] pll;
        logic [QW-1:0] plh;
        logic [QW-1:0] phl;
        logic [QW-1:0] phh;
        logic [QW:0]   mid;
        logic [PW-1:0] sum;
        nxt = '0;
        pll = '0;
        plh = '0;
        phl = '0;
        phh = '0;
        mid = '0;
        sum = '0;
        for (int i = 0; i < NB; i++) begin
          for (int j = 0; j < NB; j++) begin
            // Low/high halves of the A digit (rows) crossed with low/high halves of the B digit (columns).
            pll = taps[POFF + ((2*i)*PNB     + 2*j    )*QW +: QW];
            plh = taps[POFF + ((2*i)*PNB     + 2*j + 1)*QW +: QW];
            phl = taps[POFF + ((2*i + 1)*PNB + 2*j    )*QW +: QW];
            phh = taps[POFF + ((2*i + 1)*PNB + 2*j + 1)*QW +: QW];
            mid = {1'b0, phl} + {1'b0, plh};
            sum = PW'(pll) + (PW'(mid) << H) + (PW'(phh) << BW);
`ifdef VEDIC_SIGNED_EN
            if (k == LAT - 1 && sgn_q[k-1]) sum = -sum;
`endif
            nxt[(i*NB + j)*PW +: PW] = sum;
          end
        end
      end
    end

    // Data only loads when valid data advances into this level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (load) begin
        q <= nxt;
      end
    end

    assign taps[OFF +: LEN] = q;
  end

endmodule

// File: tb/tb_vedic_multiplier_pipe.sv
module tb_vedic_multiplier_pipe;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
`ifdef VEDIC_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vedic_multiplier_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  vedic_multiplier_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  int          popped = 0;
  int          cyc = 0;
  logic        cur_sgn = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_p = '0;
  logic [3:0]  held_tag = '0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Reference: plain integer multiplication, signed operands interpreted as two's complement.
  function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    longint x;
    longint y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t, input logic s);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.in_tag   = t;
    cur_sgn      = s & SIGNED_BUILD;
`ifdef VEDIC_SIGNED_EN
    bus.in_signed = s;
`endif
  endtask

  // One clock: observe at the falling edge (handshakes that the next rising edge will honour), then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (held) begin
      check("hold_out_valid", 64'(bus.out_valid), 64'(1'b1));
      check("hold_P", 64'(bus.P), 64'(held_p));
      check("hold_out_tag", 64'(bus.out_tag), 64'(held_tag));
    end
    check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
    held     = bus.out_valid && !bus.out_ready;
    held_p   = bus.P;
    held_tag = bus.out_tag;
    if (bus.out_valid && bus.out_ready) begin
      popped++;
      got_q.push_back(bus.P);
      got_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(bus.out_valid), 64'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check("P", 64'(bus.P), 64'(e.p));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      accepted++;
      exp_q.push_back({ref_product(bus.A, bus.B, cur_sgn), bus.in_tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(bus.out_valid), 64'(1'b0));
  endtask

  initial begin
    int a0;
    int p0;
    int guard;

    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rst_P", 64'(bus.P), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair, latency 4 edges counting the accept edge
    drive(1'b1, 16'h1234, 16'h5678, 4'd3, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
    step();
    step();
    check("lat_not_early", 64'(bus.out_valid), 64'(1'b0));
    step();
    check("lat_out_valid", 64'(bus.out_valid), 64'(1'b1));
    check("lat_P", 64'(bus.P), 64'h06260060);
    check("lat_out_tag", 64'(bus.out_tag), 64'd3);
    drain();

    // Back-to-back corner products
    got_q.delete();
    got_cyc_q.delete();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 4'd1, 1'b0);
    step();
    drive(1'b1, 16'h0000, 16'hABCD, 4'd2, 1'b0);
    step();
    drive(1'b1, 16'h0001, 16'h8000, 4'd3, 1'b0);
    step();
    drain();
    check("b2b_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("b2b_P0", 64'(got_q[0]), 64'hFFFE0001);
      check("b2b_P1", 64'(got_q[1]), 64'h00000000);
      check("b2b_P2", 64'(got_q[2]), 64'h00008000);
      check("b2b_consecutive01", 64'(got_cyc_q[1] - got_cyc_q[0]), 64'd1);
      check("b2b_consecutive12", 64'(got_cyc_q[2] - got_cyc_q[1]), 64'd1);
    end

    // Backpressure: out_ready low for 5 cycles while streaming
    a0 = accepted;
    p0 = popped;
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = !(i >= 6 && i < 11);
      drive(1'b1, rand_op(), rand_op(), 4'(i), 1'b0);
      step();
    end
    drain();
    check("bp_no_loss", 64'(popped - p0), 64'(accepted - a0));

    // Reset with three pairs in flight
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 4'd5, 1'b0);
    step();
    drive(1'b1, 16'h3333, 16'h4444, 4'd6, 1'b0);
    step();
    drive(1'b1, 16'h5555, 16'h6666, 4'd7, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("midrst_P", 64'(bus.P), 64'd0);
    check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    drive(1'b1, 16'h00FF, 16'h0101, 4'd9, 1'b0);
    step();
    drain();
    check("postrst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) check("postrst_first", 64'(got_q[0]), 64'h0000FFFF);

`ifdef VEDIC_SIGNED_EN
    // Signed and unsigned interpretations of the same operands
    got_q.delete();
    drive(1'b1, 16'hFFFD, 16'h0005, 4'd1, 1'b1);
    step();
    drive(1'b1, 16'h8000, 16'h8000, 4'd2, 1'b1);
    step();
    drive(1'b1, 16'h8000, 16'h8000, 4'd3, 1'b0);
    step();
    drive(1'b1, 16'hFFFD, 16'h0005, 4'd4, 1'b0);
    step();
    drain();
    check("sgn_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check("sgn_m3x5", 64'(got_q[0]), 64'hFFFFFFF1);
      check("sgn_min_sq", 64'(got_q[1]), 64'h40000000);
      check("uns_8000_sq", 64'(got_q[2]), 64'h40000000);
      check("uns_fffdx5", 64'(got_q[3]), 64'h0004FFF1);
    end
`endif

    // Random traffic with random bubbles and backpressure
    a0 = accepted;
    p0 = popped;
    guard = 0;
    while ((accepted - a0) < 10000 && guard < 60000) begin
      drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), 4'($urandom), 1'($urandom));
      bus.out_ready = $urandom_range(0, 3) != 0;
      step();
      guard++;
    end
    check("rand_accepted", 64'(accepted - a0), 64'd10000);
    drain();
    check("rand_no_loss", 64'(popped - p0), 64'(accepted - a0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
